// File: rtl/carrack_wb_pkg.sv
// Shared types and constants for the Carrack Wishbone classic initiator.
package carrack_wb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int unsigned DEF_ADDR_W    = 32;
   localparam int unsigned DEF_DATA_W    = 32;
   localparam int unsigned ERR_COUNT_W   = 8;
   localparam int unsigned ERR_COUNT_MAX = 255;

endpackage : carrack_wb_pkg

// File: rtl/carrack_wb_initiator.sv
// Wishbone classic initiator: one single-beat bus cycle per command, with a
// programmable ack timeout, abort, and a saturating error counter.
module carrack_wb_initiator
   import carrack_wb_pkg::*;
#(
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned TIMEOUT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_we,
   input  logic [ADDR_W-1:0]      cmd_addr,
   input  logic [DATA_W-1:0]      cmd_wdata,
   input  logic [DATA_W/8-1:0]    cmd_sel,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [DATA_W-1:0]      resp_rdata,
   output logic                   resp_err,
   input  logic                   abort,
   input  logic [TIMEOUT_W-1:0]   timeout_cycles,
   output logic [ERR_COUNT_W-1:0] err_count,
   output logic                   wbm_cyc_o,
   output logic                   wbm_stb_o,
   output logic                   wbm_we_o,
   output logic [ADDR_W-1:0]      wbm_adr_o,
   output logic [DATA_W-1:0]      wbm_dat_o,
   output logic [DATA_W/8-1:0]    wbm_sel_o,
   input  logic [DATA_W-1:0]      wbm_dat_i,
   input  logic                   wbm_ack_i
);

   localparam int unsigned SEL_W = DATA_W / 8;

   state_t                 state, state_d;
   logic [TIMEOUT_W-1:0]   wait_cnt, wait_cnt_d;
   logic                   cmd_ready_d;
   logic                   resp_valid_d;
   logic [DATA_W-1:0]      resp_rdata_d;
   logic                   resp_err_d;
   logic [ERR_COUNT_W-1:0] err_count_d;
   logic                   cyc_d;
   logic                   we_d;
   logic [ADDR_W-1:0]      adr_d;
   logic [DATA_W-1:0]      dat_d;
   logic [SEL_W-1:0]       sel_d;
   logic                   timeout_hit;

   // Timeout fires on the last allowed cycle; a zero setting disables it.
   assign timeout_hit = (timeout_cycles != '0) &&
                        (wait_cnt == TIMEOUT_W'(timeout_cycles - TIMEOUT_W'(1)));

   // State and all output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         cmd_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         err_count  <= '0;
         wbm_cyc_o  <= 1'b0;
         wbm_stb_o  <= 1'b0;
         wbm_we_o   <= 1'b0;
         wbm_adr_o  <= '0;
         wbm_dat_o  <= '0;
         wbm_sel_o  <= '0;
      end else begin
         state      <= state_d;
         wait_cnt   <= wait_cnt_d;
         cmd_ready  <= cmd_ready_d;
         resp_valid <= resp_valid_d;
         resp_rdata <= resp_rdata_d;
         resp_err   <= resp_err_d;
         err_count  <= err_count_d;
         wbm_cyc_o  <= cyc_d;
         wbm_stb_o  <= cyc_d;
         wbm_we_o   <= we_d;
         wbm_adr_o  <= adr_d;
         wbm_dat_o  <= dat_d;
         wbm_sel_o  <= sel_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d      = state;
      wait_cnt_d   = wait_cnt;
      cmd_ready_d  = 1'b0;
      resp_valid_d = resp_valid;
      resp_rdata_d = resp_rdata;
      resp_err_d   = resp_err;
      err_count_d  = err_count;
      cyc_d        = wbm_cyc_o;
      we_d         = wbm_we_o;
      adr_d        = wbm_adr_o;
      dat_d        = wbm_dat_o;
      sel_d        = wbm_sel_o;

      unique case (state)
         IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready) begin
               cmd_ready_d = 1'b0;
               we_d        = cmd_we;
               adr_d       = cmd_addr;
               dat_d       = cmd_wdata;
               sel_d       = cmd_sel;
               wait_cnt_d  = '0;
               cyc_d       = 1'b1;
               state_d     = BUS;
            end
         end

         BUS: begin
            if (wbm_ack_i) begin
               cyc_d        = 1'b0;
               resp_valid_d = 1'b1;
               resp_rdata_d = wbm_we_o ? '0 : wbm_dat_i;
               resp_err_d   = 1'b0;
               state_d      = RESP;
            end else if (abort || timeout_hit) begin
               cyc_d        = 1'b0;
               resp_valid_d = 1'b1;
               resp_rdata_d = '0;
               resp_err_d   = 1'b1;
               state_d      = RESP;
               if (err_count != ERR_COUNT_W'(ERR_COUNT_MAX)) begin
                  err_count_d = err_count + ERR_COUNT_W'(1);
               end
            end else begin
               wait_cnt_d = wait_cnt + TIMEOUT_W'(1);
            end
         end

         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               cmd_ready_d  = 1'b1;
               state_d      = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule : carrack_wb_initiator

// File: doc/carrack_wb_initiator.md
Name: carrack_wb_initiator

Overview:
Wishbone classic initiator (master) for the Carrack user area. It is the opposite end of the Wishbone slave port that carrack_wrapper exposes to the management SoC.
It accepts single-beat read/write commands from an internal client over a valid/ready command channel and runs one classic Wishbone cycle per command. It returns read data and error status over a valid/ready response channel.
A programmable timeout bounds every bus cycle. A saturating error counter records failed transactions.

Parameters:
ADDR_W, 32, Wishbone address width.
DATA_W, 32, Wishbone data width; SEL width is DATA_W/8.
TIMEOUT_W, 8, width of the timeout counter and of the timeout_cycles input.

Ports:
clk  in  1  single clock for all logic.
rst_n  in  1  asynchronous reset, active-low.
cmd_valid  in  1  command offered.
cmd_ready  out  1  command accepted when high together with cmd_valid.
cmd_we  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_W  byte address.
cmd_wdata  in  DATA_W  write data.
cmd_sel  in  DATA_W/8  byte enables.
resp_valid  out  1  response available.
resp_ready  in  1  response consumed when high together with resp_valid.
resp_rdata  out  DATA_W  read data; 0 for writes and for errors.
resp_err  out  1  1 = timeout or abort.
abort  in  1  terminates an in-flight cycle.
timeout_cycles  in  TIMEOUT_W  maximum wait for ack; 0 disables the timeout.
err_count  out  8  saturating count of errored transactions.
wbm_cyc_o  out  1  Wishbone CYC.
wbm_stb_o  out  1  Wishbone STB.
wbm_we_o  out  1  Wishbone WE.
wbm_adr_o  out  ADDR_W  Wishbone address.
wbm_dat_o  out  DATA_W  Wishbone write data.
wbm_sel_o  out  DATA_W/8  Wishbone byte select.
wbm_dat_i  in  DATA_W  Wishbone read data.
wbm_ack_i  in  1  Wishbone acknowledge.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, rst_n low): state IDLE; all outputs 0; err_count = 0. If rst_n falls mid-cycle, cyc/stb drop immediately and no response is produced.
- FSM has three states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready at edge N: latch we/addr/wdata/sel into the wbm_* outputs, clear the wait counter, go to BUS.
  - wbm_cyc_o and wbm_stb_o are high from cycle N+1.
- BUS:
  - cmd_ready = 0; cyc = stb = 1; wbm_adr_o, wbm_dat_o, wbm_we_o and wbm_sel_o are held stable.
  - The wait counter increments every cycle without ack.
- BUS exits are checked in this priority order; on every exit cyc/stb drop on the same edge:
  1. ack: wbm_ack_i high at edge M → capture wbm_dat_i into resp_rdata (reads only; writes return 0), resp_err = 0, go to RESP. resp_valid is high from cycle M+1. Minimum command-to-response latency is 2 cycles when ack arrives on the first cycle of BUS.
  2. abort: abort high at the edge → resp_err = 1, resp_rdata = 0, go to RESP.
  3. timeout: timeout_cycles != 0 and wait counter == timeout_cycles - 1 with no ack → resp_err = 1, resp_rdata = 0, go to RESP. The cycle therefore lasts exactly timeout_cycles cycles.
- Ack and abort on the same edge: ack wins, so the transaction completes successfully.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable until resp_ready.
  - On resp_valid && resp_ready → IDLE; resp_valid drops next cycle.
  - cmd_ready rises next cycle; a new command cannot be accepted on the response-handshake edge.
- err_count increments on every transition into RESP with resp_err = 1 and saturates at 255.
- Stray wbm_ack_i in IDLE or RESP is ignored and has no effect on any state.
- abort outside BUS is ignored.
- A timeout_cycles change during BUS takes effect immediately. If the new value is below the current count, the timeout fires when the count next equals the new value - 1 after wrap-around; this case must not hang, and no ack is required for the cycle to end.

Decomposition:
- Shared package carrack_wb_pkg holds:
  - the state enum (IDLE, BUS, RESP);
  - the default widths ADDR_W = 32 and DATA_W = 32;
  - the ERR_COUNT_MAX = 255 constant.
- No sub-module. The wait counter and the err_count saturator are inline.

Test Plan:
- Write: cmd we=1, addr=0x3000_0004, wdata=0xDEAD_BEEF, sel=0xF; slave acks 3 cycles after cyc → wbm_* stable for all 3 cycles; resp_valid with resp_err=0, rdata=0; cyc low on the ack+1 cycle.
- Read: cmd we=0, addr=0x3000_0000; ack in the first BUS cycle returning 0x1234_5678 → resp_valid 2 cycles after cmd accept; rdata=0x1234_5678.
- Timeout: timeout_cycles=5, no ack → cyc high exactly 5 cycles; resp_err=1; rdata=0; err_count=1. Then timeout_cycles=0 with ack after 300 cycles → completes with err=0.
- Backpressure and simultaneous events: hold resp_ready=0 for 10 cycles → resp fields stable and cmd_ready=0 throughout. Ack and abort on the same edge → resp_err=0.
- Abort and saturation: abort in the 2nd BUS cycle → cyc drops, resp_err=1. Run 260 timed-out transactions → err_count stuck at 255.
- Reset mid-cycle: pull rst_n low while in BUS → cyc/stb/resp_valid go 0 asynchronously (no clock edge needed); after release, state IDLE and cmd_ready=1 on the first clock.
